// File: rtl/ysyx_24090018_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_24090018_mem_arb
//  Purpose  : Round-robin arbiter sharing one memory port between the IFU
//             and the LSU. One transaction in flight at a time, with a
//             watchdog that forces an error response if memory stalls.
//  Ports    : clk, rst             - clock, synchronous active-high reset
//             ifu_req_* / ifu_rsp_* - IFU read request / response channel
//             lsu_req_* / lsu_rsp_* - LSU read/write request / response channel
//             mem_req_* / mem_rsp_* - shared memory request / response port
//  Revision : 1.0 - initial release
// ============================================================================
module ysyx_24090018_mem_arb #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    // IFU channel
    input  logic        ifu_req_valid_i,
    output logic        ifu_req_ready_o,
    input  logic [31:0] ifu_addr_i,
    output logic        ifu_rsp_valid_o,
    output logic [31:0] ifu_rdata_o,
    output logic        ifu_rsp_err_o,
    // LSU channel
    input  logic        lsu_req_valid_i,
    output logic        lsu_req_ready_o,
    input  logic [31:0] lsu_addr_i,
    input  logic        lsu_wen_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [3:0]  lsu_wmask_i,
    output logic        lsu_rsp_valid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_rsp_err_o,
    // shared memory port
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_wen_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wmask_o,
    input  logic        mem_rsp_valid_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    localparam logic       OWN_IFU   = 1'b0;
    localparam logic       OWN_LSU   = 1'b1;
    localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q,  last_d;
    logic [31:0] addr_q,  addr_d;
    logic        wen_q,   wen_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [7:0]  cnt_q,   cnt_d;

    logic        w_grant_lsu;
    logic        w_idle;
    logic        w_cnt_hit;
    logic        w_rsp_ok;
    logic        w_rsp_to;
    logic        w_rsp;
    logic        w_ifu_acc;
    logic        w_lsu_acc;
    logic [7:0]  w_cnt_inc;

    // Grant / handshake / response decode. Readies depend only on state and
    // request valids, never on the memory response path. Every output is
    // forced low while rst is asserted so nothing leaks out mid-reset.
    always_comb begin
        w_grant_lsu = lsu_req_valid_i && (!ifu_req_valid_i || (last_q == OWN_IFU));
        w_idle      = (state_q == S_IDLE) && !rst;

        ifu_req_ready_o = w_idle && ifu_req_valid_i && !w_grant_lsu;
        lsu_req_ready_o = w_idle && w_grant_lsu;
        w_ifu_acc       = ifu_req_ready_o;
        w_lsu_acc       = lsu_req_ready_o;

        w_cnt_hit = (cnt_q == C_TO_LAST);
        w_cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

        // A real response always beats a coincident timeout.
        w_rsp_ok = !rst && (state_q == S_WAIT) && mem_rsp_valid_i;
        w_rsp_to = !rst && w_cnt_hit &&
                   (((state_q == S_WAIT) && !mem_rsp_valid_i) ||
                    ((state_q == S_REQ)  && !mem_req_ready_i));
        w_rsp    = w_rsp_ok || w_rsp_to;

        ifu_rsp_valid_o = w_rsp && (owner_q == OWN_IFU);
        lsu_rsp_valid_o = w_rsp && (owner_q == OWN_LSU);
        ifu_rsp_err_o   = ifu_rsp_valid_o && w_rsp_to;
        lsu_rsp_err_o   = lsu_rsp_valid_o && w_rsp_to;
        ifu_rdata_o     = (ifu_rsp_valid_o && w_rsp_ok) ? mem_rdata_i : 32'h0;
        lsu_rdata_o     = (lsu_rsp_valid_o && w_rsp_ok) ? mem_rdata_i : 32'h0;

        mem_req_valid_o = !rst && (state_q == S_REQ);
        mem_addr_o      = mem_req_valid_o ? addr_q  : 32'h0;
        mem_wen_o       = mem_req_valid_o && wen_q;
        mem_wdata_o     = mem_req_valid_o ? wdata_q : 32'h0;
        mem_wmask_o     = mem_req_valid_o ? wmask_q : 4'h0;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (w_ifu_acc || w_lsu_acc) begin
                    owner_d = w_lsu_acc ? OWN_LSU : OWN_IFU;
                    last_d  = w_lsu_acc ? OWN_LSU : OWN_IFU;
                    // Instruction fetches are always full-word reads.
                    addr_d  = w_lsu_acc ? lsu_addr_i  : ifu_addr_i;
                    wen_d   = w_lsu_acc && lsu_wen_i;
                    wdata_d = w_lsu_acc ? lsu_wdata_i : 32'h0;
                    wmask_d = w_lsu_acc ? lsu_wmask_i : 4'hF;
                    cnt_d   = 8'd0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                cnt_d = w_cnt_inc;
                if (mem_req_ready_i) begin
                    state_d = S_WAIT;
                end else if (w_cnt_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_d = w_cnt_inc;
                if (mem_rsp_valid_i || w_cnt_hit) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= OWN_IFU;
            last_q  <= OWN_IFU;
            addr_q  <= 32'h0;
            wen_q   <= 1'b0;
            wdata_q <= 32'h0;
            wmask_q <= 4'h0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24090018_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_24090018_mem_arb
//  Purpose  : Self-checking bench for ysyx_24090018_mem_arb. A transaction
//             level model (busy flag, age since acceptance, handshake flag)
//             predicts every output each cycle; directed scenarios add
//             explicit checks on the key values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_24090018_mem_arb;

    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ifu_v, ifu_r, ifu_rv, ifu_re;
    logic [31:0] ifu_a, ifu_rd;
    logic        lsu_v, lsu_r, lsu_wen, lsu_rv, lsu_re;
    logic [31:0] lsu_a, lsu_wd, lsu_rd;
    logic [3:0]  lsu_wm;
    logic        mem_v, mem_rdy, mem_wen, mem_rspv;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic [3:0]  mem_wm;

    ysyx_24090018_mem_arb #(.TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .ifu_req_valid_i (ifu_v),
        .ifu_req_ready_o (ifu_r),
        .ifu_addr_i      (ifu_a),
        .ifu_rsp_valid_o (ifu_rv),
        .ifu_rdata_o     (ifu_rd),
        .ifu_rsp_err_o   (ifu_re),
        .lsu_req_valid_i (lsu_v),
        .lsu_req_ready_o (lsu_r),
        .lsu_addr_i      (lsu_a),
        .lsu_wen_i       (lsu_wen),
        .lsu_wdata_i     (lsu_wd),
        .lsu_wmask_i     (lsu_wm),
        .lsu_rsp_valid_o (lsu_rv),
        .lsu_rdata_o     (lsu_rd),
        .lsu_rsp_err_o   (lsu_re),
        .mem_req_valid_o (mem_v),
        .mem_req_ready_i (mem_rdy),
        .mem_addr_o      (mem_a),
        .mem_wen_o       (mem_wen),
        .mem_wdata_o     (mem_wd),
        .mem_wmask_o     (mem_wm),
        .mem_rsp_valid_i (mem_rspv),
        .mem_rdata_i     (mem_rd)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Transaction-level model state
    bit          m_busy, m_hs, m_own, m_last;
    logic [68:0] m_fields;
    int          m_age;

    // Expected outputs for the current cycle
    logic        e_ir, e_lr, e_mv, e_iv, e_ie, e_lv, e_le;
    logic [68:0] e_mf;
    logic [31:0] e_ird, e_lrd;
    bit          e_done, e_hs;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Settle mid-cycle, predict all outputs, compare.
    task automatic settle(input string tag);
        logic        rsp, err;
        logic [31:0] rd;
        #4;
        e_ir = 0; e_lr = 0; e_mv = 0; e_iv = 0; e_ie = 0; e_lv = 0; e_le = 0;
        e_mf = '0; e_ird = 0; e_lrd = 0; e_done = 0; e_hs = 0;
        rsp = 0; err = 0; rd = 0;
        if (!rst) begin
            if (!m_busy) begin
                // round robin: on conflict, the one that did not win last time
                e_lr = lsu_v && (!ifu_v || !m_last);
                e_ir = ifu_v && !e_lr;
            end else begin
                if (!m_hs) begin
                    e_mv = 1; e_mf = m_fields;
                    if (mem_rdy) e_hs = 1;
                    else if (m_age == TO) begin rsp = 1; err = 1; end
                end else if (mem_rspv) begin
                    rsp = 1; rd = mem_rd;
                end else if (m_age == TO) begin
                    rsp = 1; err = 1;
                end
                e_done = rsp;
                if (m_own) begin e_lv = rsp; e_le = err; e_lrd = rd; end
                else       begin e_iv = rsp; e_ie = err; e_ird = rd; end
            end
        end
        chk({tag, ".ifu_ready"}, ifu_r, e_ir);
        chk({tag, ".lsu_ready"}, lsu_r, e_lr);
        chk({tag, ".mem_valid"}, mem_v, e_mv);
        chk({tag, ".mem_fields"}, {mem_a, mem_wen, mem_wd, mem_wm}, e_mf);
        chk({tag, ".ifu_rsp"}, {ifu_rv, ifu_re, ifu_rd}, {e_iv, e_ie, e_ird});
        chk({tag, ".lsu_rsp"}, {lsu_rv, lsu_re, lsu_rd}, {e_lv, e_le, e_lrd});
    endtask

    // Clock edge: advance the model, then step off the edge.
    task automatic adv();
        @(posedge clk);
        if (rst) begin
            m_busy = 0; m_hs = 0; m_last = 0; m_own = 0; m_fields = '0; m_age = 0;
        end else if (!m_busy) begin
            if (e_ir || e_lr) begin
                m_busy = 1; m_hs = 0; m_age = 1; m_own = e_lr; m_last = e_lr;
                m_fields = e_lr ? {lsu_a, lsu_wen, lsu_wd, lsu_wm}
                                : {ifu_a, 1'b0, 32'h0, 4'hF};
            end
        end else if (e_done) begin
            m_busy = 0;
        end else begin
            if (e_hs) m_hs = 1;
            m_age++;
        end
        #1;
    endtask

    task automatic step(input string tag);
        settle(tag);
        adv();
    endtask

    initial begin
        rst = 1; ifu_v = 0; ifu_a = 0; lsu_v = 0; lsu_a = 0; lsu_wen = 0;
        lsu_wd = 0; lsu_wm = 0; mem_rdy = 0; mem_rspv = 0; mem_rd = 0;
        m_busy = 0; m_hs = 0; m_own = 0; m_last = 0; m_fields = '0; m_age = 0;
        step("reset0");
        step("reset1");
        rst = 0;

        // IFU fetch at minimum latency
        ifu_v = 1; ifu_a = 32'h8000_0000; mem_rdy = 1;
        settle("fetch.c0"); chk("fetch.c0.ready", ifu_r, 1'b1); adv();
        ifu_v = 0; ifu_a = 32'h0;
        settle("fetch.c1"); chk("fetch.c1.mem", {mem_v, mem_a}, {1'b1, 32'h8000_0000}); adv();
        mem_rspv = 1; mem_rd = 32'h0000_0513; mem_rdy = 0;
        settle("fetch.c2"); chk("fetch.c2.rsp", {ifu_rv, ifu_re, ifu_rd}, {1'b1, 1'b0, 32'h0000_0513}); adv();
        mem_rspv = 0; mem_rd = 0;

        // Round robin from reset: LSU, IFU, LSU, IFU
        rst = 1; step("rr.rst"); rst = 0;
        ifu_v = 1; ifu_a = 32'h8000_0100; lsu_v = 1; lsu_a = 32'h8000_2000; mem_rdy = 1;
        for (int i = 0; i < 4; i++) begin
            settle("rr.acc");
            chk("rr.grant", {ifu_r, lsu_r}, (i % 2 == 0) ? 2'b01 : 2'b10);
            adv();
            step("rr.req");
            mem_rspv = 1; mem_rd = $urandom;
            step("rr.wait");
            mem_rspv = 0;
        end
        ifu_v = 0; lsu_v = 0; mem_rdy = 0;

        // LSU store held in REQ for 6 cycles
        lsu_v = 1; lsu_a = 32'h8000_1000; lsu_wen = 1; lsu_wd = 32'hDEAD_BEEF; lsu_wm = 4'b0011;
        step("st.acc");
        lsu_v = 0; lsu_a = 0; lsu_wen = 0; lsu_wd = 0; lsu_wm = 0;
        for (int i = 0; i < 6; i++) begin
            mem_rdy = (i == 5);
            settle("st.req");
            chk("st.hold", {mem_v, mem_a, mem_wen, mem_wd, mem_wm},
                {1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'b0011});
            adv();
        end
        mem_rdy = 0; mem_rspv = 1; mem_rd = 32'h1111_2222;
        settle("st.rsp"); chk("st.rsp", {lsu_rv, lsu_re, lsu_rd}, {1'b1, 1'b0, 32'h1111_2222}); adv();
        mem_rspv = 0;

        // Timeout: no response, error exactly TO cycles after acceptance
        ifu_v = 1; ifu_a = 32'h8000_0040; mem_rdy = 1;
        step("to.acc");
        ifu_v = 0;
        for (int age = 1; age <= 8; age++) begin
            settle("to.run");
            if (age == 8) chk("to.err", {ifu_rv, ifu_re, ifu_rd}, {1'b1, 1'b1, 32'h0});
            else          chk("to.quiet", ifu_rv, 1'b0);
            adv();
            mem_rdy = 0;
        end
        ifu_v = 1;
        settle("to.idle"); chk("to.idle", ifu_r, 1'b1); adv();
        ifu_v = 0; mem_rdy = 1; step("to.req2");
        mem_rdy = 0; mem_rspv = 1; step("to.rsp2"); mem_rspv = 0;

        // Response coinciding with the timeout cycle wins
        lsu_v = 1; lsu_a = 32'h8000_3000; mem_rdy = 1;
        step("co.acc");
        lsu_v = 0;
        step("co.req");
        mem_rdy = 0;
        for (int age = 2; age < 8; age++) step("co.wait");
        mem_rspv = 1; mem_rd = 32'h0000_CAFE;
        settle("co.rsp"); chk("co.rsp", {lsu_rv, lsu_re, lsu_rd}, {1'b1, 1'b0, 32'h0000_CAFE}); adv();
        mem_rspv = 0;

        // Reset while waiting drops the transaction
        ifu_v = 1; ifu_a = 32'h8000_0080; mem_rdy = 1;
        step("rw.acc");
        ifu_v = 0;
        step("rw.req");
        mem_rdy = 0; rst = 1;
        settle("rw.rst"); chk("rw.rst.quiet", {ifu_rv, lsu_rv, ifu_r, lsu_r}, 4'b0); adv();
        rst = 0; mem_rspv = 1; mem_rd = 32'h5555_AAAA;
        settle("rw.stale"); chk("rw.stale", {ifu_rv, lsu_rv}, 2'b0); adv();
        mem_rspv = 0; ifu_v = 1; ifu_a = 32'h8000_0084; mem_rdy = 1;
        step("rw.acc2");
        ifu_v = 0;
        step("rw.req2");
        mem_rdy = 0; mem_rspv = 1; mem_rd = 32'h0000_0013;
        settle("rw.rsp2"); chk("rw.rsp2", {ifu_rv, ifu_re, ifu_rd}, {1'b1, 1'b0, 32'h0000_0013}); adv();
        mem_rspv = 0;

        // Spurious memory response while idle
        mem_rspv = 1; mem_rd = 32'hFFFF_FFFF;
        settle("sp.idle"); chk("sp.quiet", {ifu_rv, lsu_rv}, 2'b0); adv();
        mem_rspv = 0; lsu_v = 1; lsu_a = 32'h8000_4000;
        settle("sp.next"); chk("sp.still_idle", lsu_r, 1'b1); adv();
        lsu_v = 0;

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 99) == 0);
            ifu_v    = 1'($urandom_range(0, 1));
            ifu_a    = $urandom;
            lsu_v    = 1'($urandom_range(0, 1));
            lsu_a    = $urandom;
            lsu_wen  = 1'($urandom_range(0, 1));
            lsu_wd   = $urandom;
            lsu_wm   = 4'($urandom_range(0, 15));
            mem_rdy  = ($urandom_range(0, 2) == 0);
            mem_rspv = ($urandom_range(0, 3) == 0);
            mem_rd   = $urandom;
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_24090018_mem_arb.md
YSYX_24090018_MEM_ARB -- requirements
Module: ysyx_24090018_mem_arb

Interface
REQ-001 Parameter TIMEOUT, default 255: cycles allowed in REQ+WAIT before an error response is forced; range 2..255.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 ifu_req_valid  in  1 / ifu_req_ready  out  1 / ifu_addr  in  32: IFU read request channel.
REQ-005 ifu_rsp_valid  out  1 / ifu_rdata  out  32 / ifu_rsp_err  out  1: IFU response channel.
REQ-006 lsu_req_valid  in  1 / lsu_req_ready  out  1 / lsu_addr  in  32 / lsu_wen  in  1 / lsu_wdata  in  32 / lsu_wmask  in  4: LSU request channel.
REQ-007 lsu_rsp_valid  out  1 / lsu_rdata  out  32 / lsu_rsp_err  out  1: LSU response channel.
REQ-008 mem_req_valid  out  1 / mem_req_ready  in  1 / mem_addr  out  32 / mem_wen  out  1 / mem_wdata  out  32 / mem_wmask  out  4: shared memory request port.
REQ-009 mem_rsp_valid  in  1 / mem_rdata  in  32: shared memory response port.

Function
REQ-010 The block SHALL implement the FSM states IDLE, REQ and WAIT, plus registers owner (IFU/LSU), last_grant (IFU/LSU), captured request fields, and an 8-bit timeout counter.
REQ-011 In IDLE with only one requester valid, the block SHALL grant that requester.
REQ-012 In IDLE with both valid, the block SHALL grant the requester not equal to last_grant (round-robin); last_grant resets to IFU, so the first conflict goes to LSU.
REQ-013 x_req_ready SHALL be 1 only in IDLE and only for the granted requester; both readies SHALL be 0 in REQ and WAIT.
REQ-014 On acceptance (valid&ready), the block SHALL capture addr/wen/wdata/wmask (IFU: wen=0, wdata=0, wmask=4'hF), set owner and last_grant, clear the counter and go to REQ.
REQ-015 In REQ, mem_req_valid SHALL be 1 and mem_* SHALL drive the captured fields, held stable until mem_req_ready; mem_req_ready=1 moves the FSM to WAIT.
REQ-016 Outside REQ, mem_req_valid SHALL be 0 and mem_addr/mem_wen/mem_wdata/mem_wmask SHALL be 0.
REQ-017 In WAIT, mem_rsp_valid=1 SHALL produce owner x_rsp_valid=1 in the same cycle, with x_rdata=mem_rdata and x_rsp_err=0; the FSM returns to IDLE next cycle.
REQ-018 The non-owner rsp_valid SHALL be 0 at all times; rdata outputs SHALL be 0 when their rsp_valid is 0.
REQ-019 mem_rsp_valid outside WAIT SHALL be ignored and generate no response.
REQ-020 The counter SHALL increment each cycle in REQ or WAIT and saturate.
REQ-021 When the counter equals TIMEOUT-1 and no mem_rsp_valid (WAIT) or mem_req_ready (REQ) occurs that cycle, the block SHALL emit owner x_rsp_valid=1, x_rsp_err=1, x_rdata=0, and return to IDLE.
REQ-022 If mem_rsp_valid and the timeout coincide, the normal response SHALL win (err=0).
REQ-023 Minimum latency SHALL be: accept in cycle 0, mem_req_valid in cycle 1, response in cycle 2 at earliest, next acceptance in cycle 3.
REQ-024 At most one transaction SHALL be outstanding; there are no combinational paths from mem_rsp_valid to any x_req_ready.

Reset
REQ-025 While rst=1 at a clock edge, the block SHALL enter IDLE, set owner=IFU, last_grant=IFU, counter=0 and clear captured fields.
REQ-026 During and after reset, all ready, valid and err outputs SHALL be 0 until a new acceptance; an in-flight transaction interrupted by reset SHALL be dropped with no response.

Verification
REQ-027 IFU only: ifu_addr=0x8000_0000, mem_req_ready=1, mem_rsp_valid in cycle 2 with rdata=0x0000_0513 -> ifu_rsp_valid=1, ifu_rdata=0x0000_0513, err=0 in cycle 2.
REQ-028 Both valid from reset -> LSU granted first; on the next conflict IFU is granted; grants alternate across 4 back-to-back conflicts.
REQ-029 LSU store addr=0x8000_1000, wdata=0xDEAD_BEEF, wmask=4'b0011, mem_req_ready held 0 for 5 cycles -> mem_* fields stable for all 6 REQ cycles.
REQ-030 TIMEOUT=8, no mem_rsp_valid -> owner rsp_valid=1, err=1 exactly 8 cycles after acceptance; FSM in IDLE the next cycle.
REQ-031 rst=1 in WAIT, then mem_rsp_valid=1 after reset -> no rsp_valid on either channel; a subsequent IFU request completes normally.
REQ-032 Spurious mem_rsp_valid in IDLE -> no rsp_valid; state unchanged.
